// File: rtl/fa_operand_seq_pkg.sv
// Shared types and defaults for the operand sequencer and its RAM.
package fa_seq_pkg;

    localparam int W         = 2;
    localparam int DEF_DEPTH = 16;
    localparam int DEF_AW    = 4;

    typedef enum logic [1:0] {
        IDLE,
        PREFETCH,
        RUN,
        FIN
    } state_t;

    // a sits in the MSBs so the packed layout matches the host's {a,b,c} word.
    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] c;
    } triple_t;

    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned depth);
        return (len > depth) ? depth : len;
    endfunction

endpackage

// File: rtl/fa_operand_seq_if.sv
// Operand stream towards the adder: one {a,b,c} triple per valid/ready transfer.
interface fa_operand_seq_if;
    import fa_seq_pkg::*;

    logic [W-1:0] a_out;
    logic [W-1:0] b_out;
    logic [W-1:0] c_out;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output a_out,
        output b_out,
        output c_out,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  a_out,
        input  b_out,
        input  c_out,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/fa_operand_ram.sv
// Operand store: DEPTH triples, one write port and one registered read port.
// Latency: read data valid one cycle after re; write-first when re/we hit the same address.
// Backpressure: none; the read register holds its value whenever re is low.
module fa_operand_ram
    import fa_seq_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  triple_t       wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output triple_t       rdata
);

    triple_t mem [DEPTH];

    // Storage itself is never reset; only the output register is.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Bypass lets a host write and a start in the same cycle see the new word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
        end
    end

endmodule

// File: rtl/fa_operand_seq.sv
// Streams up to DEPTH preloaded {a,b,c} triples to the adder after a start pulse.
// Latency: first valid two cycles after start, then one triple per cycle; done one cycle after the last transfer.
// Backpressure: out_ready low stalls the stream with data and valid held stable.
module fa_operand_seq
    import fa_seq_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  triple_t          wr_data,
    input  logic             start,
    input  logic [AW:0]      len,
    fa_operand_seq_if.master out_if,
    output logic             busy,
    output logic             done,
    output logic [AW:0]      idx
);

    localparam logic [AW:0]   IDX_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] ADDR_ONE = AW'(1);

    state_t        state_q;
    state_t        state_d;
    logic [AW:0]   n_q;
    logic [AW:0]   idx_q;
    logic          valid_int;
    logic          start_acc;
    logic          xfer;
    logic          last;
    logic          wr_ok;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    triple_t       rd_data;

    assign start_acc = start && (state_q == IDLE);
    assign xfer      = valid_int && out_if.out_ready;
    assign last      = (idx_q + IDX_ONE) == n_q;
    assign wr_ok     = wr_en && !busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (len == '0) ? FIN : PREFETCH;
                end
            end
            PREFETCH: state_d = RUN;
            RUN: begin
                if (xfer && last) begin
                    state_d = FIN;
                end
            end
            FIN:      state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        valid_int = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE:     busy = 1'b0;
            PREFETCH: busy = 1'b1;
            RUN: begin
                busy      = 1'b1;
                valid_int = 1'b1;
            end
            FIN: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default:  busy = 1'b0;
        endcase
    end

    // n is the clamped run length; idx keeps its final count until the next start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q   <= '0;
            idx_q <= '0;
        end else if (start_acc) begin
            n_q   <= (AW+1)'(clamp_len(32'(len), $unsigned(DEPTH)));
            idx_q <= '0;
        end else if (xfer) begin
            idx_q <= idx_q + IDX_ONE;
        end
    end

    // Fetching idx+1 on the transfer edge is what keeps the stream bubble-free;
    // with no transfer the read register is left alone so the outputs hold.
    always_comb begin
        rd_en   = 1'b0;
        rd_addr = idx_q[AW-1:0];
        if (state_q == IDLE) begin
            rd_en   = start && (len != '0);
            rd_addr = '0;
        end else if (xfer) begin
            rd_en   = !last;
            rd_addr = idx_q[AW-1:0] + ADDR_ONE;
        end
    end

    fa_operand_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_ok),
        .waddr (wr_addr),
        .wdata (wr_data),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    assign out_if.a_out     = rd_data.a;
    assign out_if.b_out     = rd_data.b;
    assign out_if.c_out     = rd_data.c;
    assign out_if.out_valid = valid_int;
    assign idx              = idx_q;

endmodule
